// File: rtl/alu_result_display.sv
// alu_result_display: captures an ALU result and its {N,Z,C,V} flags on a
// load handshake and scans them onto a 4-digit, active-low 7-segment display.
// Digits 0-2 show the result in hex (zero-extended to 12 bits), digit 3 shows
// the flag nibble. Digits 1-2 that lie entirely above the result width are
// blanked while their slot still elapses, so the scan period stays fixed.
module alu_result_display #(
   parameter int unsigned N           = 4,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] result_in,
   input  logic [3:0]   flags_in,
   input  logic         load,
   input  logic         hold,
   output logic         load_ack,
   output logic [N-1:0] result_q,
   output logic [3:0]   flags_q,
   output logic [3:0]   an,
   output logic [6:0]   seg
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      DIGIT0 = 2'd0,
      DIGIT1 = 2'd1,
      DIGIT2 = 2'd2,
      DIGIT3 = 2'd3
   } digit_t;

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   digit_t           digit;
   digit_t           digit_next;

   logic [11:0]      result_ext;
   logic [3:0]       nibble;
   logic             blank;
   logic [3:0]       an_next;
   logic [6:0]       seg_next;

   // Active-low hex encoding, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Capture handshake: reset beats load, hold freezes the captured values.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         flags_q  <= '0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= load & ~hold;
         if (load && !hold) begin
            result_q <= result_in;
            flags_q  <= flags_in;
         end
      end
   end

   assign wrap = (cnt == CNT_MAX);

   // Digit sequencing 0 -> 1 -> 2 -> 3 -> 0.
   always_comb begin
      digit_next = DIGIT0;
      case (digit)
         DIGIT0:  digit_next = DIGIT1;
         DIGIT1:  digit_next = DIGIT2;
         DIGIT2:  digit_next = DIGIT3;
         default: digit_next = DIGIT0;
      endcase
   end

   // Refresh counter; the digit select advances on each counter wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         digit <= DIGIT0;
      end else begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
         if (wrap) begin
            digit <= digit_next;
         end
      end
   end

   // Zero-extend the captured result to the three displayable nibbles.
   always_comb begin
      result_ext         = '0;
      result_ext[N-1:0]  = result_q;
   end

   // Select the nibble and enable for the current digit, blanking upper
   // result digits that carry no bits of the result.
   always_comb begin
      nibble  = result_ext[3:0];
      blank   = 1'b0;
      an_next = 4'b1110;
      case (digit)
         DIGIT0: begin
            nibble  = result_ext[3:0];
            an_next = 4'b1110;
         end
         DIGIT1: begin
            nibble  = result_ext[7:4];
            blank   = (N <= 4);
            an_next = 4'b1101;
         end
         DIGIT2: begin
            nibble  = result_ext[11:8];
            blank   = (N <= 8);
            an_next = 4'b1011;
         end
         default: begin
            nibble  = flags_q;
            an_next = 4'b0111;
         end
      endcase
      seg_next = hex7(nibble);
      if (blank) begin
         an_next  = '1;
         seg_next = '1;
      end
   end

   // Registered display outputs; one cycle behind the digit select.
   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= '1;
         seg <= '1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed testbench for alu_result_display: three instances (N=4, 8, 12)
// share clock and stimulus with REFRESH_DIV=4 so blanking rules are visible.
module tb_alu_result_display;

   localparam int unsigned DIV = 4;

   logic        clk;
   logic        reset;
   logic        load;
   logic        hold;
   logic [11:0] value;
   logic [3:0]  flags;

   logic [3:0]  r4_in;
   logic [7:0]  r8_in;
   logic [11:0] r12_in;

   logic        ack4, ack8, ack12;
   logic [3:0]  rq4;
   logic [7:0]  rq8;
   logic [11:0] rq12;
   logic [3:0]  fq4, fq8, fq12;
   logic [3:0]  an4, an8, an12;
   logic [6:0]  seg4, seg8, seg12;

   int unsigned checks = 0;
   int unsigned errors = 0;

   assign r4_in  = value[3:0];
   assign r8_in  = value[7:0];
   assign r12_in = value;

   alu_result_display #(.N(4), .REFRESH_DIV(DIV)) u4 (
      .clk(clk), .reset(reset), .result_in(r4_in), .flags_in(flags),
      .load(load), .hold(hold), .load_ack(ack4), .result_q(rq4),
      .flags_q(fq4), .an(an4), .seg(seg4)
   );

   alu_result_display #(.N(8), .REFRESH_DIV(DIV)) u8 (
      .clk(clk), .reset(reset), .result_in(r8_in), .flags_in(flags),
      .load(load), .hold(hold), .load_ack(ack8), .result_q(rq8),
      .flags_q(fq8), .an(an8), .seg(seg8)
   );

   alu_result_display #(.N(12), .REFRESH_DIV(DIV)) u12 (
      .clk(clk), .reset(reset), .result_in(r12_in), .flags_in(flags),
      .load(load), .hold(hold), .load_ack(ack12), .result_q(rq12),
      .flags_q(fq12), .an(an12), .seg(seg12)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves reset low just after a reset edge; the next edge is "edge 1".
   task automatic do_reset(input int unsigned cycles);
      reset = 1'b1;
      load  = 1'b0;
      hold  = 1'b0;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] ea4, ea12;
      logic [6:0] es4;
      int unsigned slot;
      reset = 1'b1; load = 1'b1; hold = 1'b0; value = 12'hFFF; flags = 4'hF;
      repeat (3) begin
         step();
         checks++; if (an4 !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected %b", an4, 4'b1111); end
         checks++; if (seg4 !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg4, 7'b1111111); end
         checks++; if (rq4 !== 4'h0) begin errors++; $display("FAIL reset_result4: got %h expected %h", rq4, 4'h0); end
         checks++; if (rq12 !== 12'h000) begin errors++; $display("FAIL reset_result12: got %h expected %h", rq12, 12'h000); end
         checks++; if (ack12 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected %b", ack12, 1'b0); end
      end
      reset = 1'b0; load = 1'b0; value = 12'h000; flags = 4'h0;
      checks++; if (an12 !== 4'b1111) begin errors++; $display("FAIL release_an_pre: got %b expected %b", an12, 4'b1111); end
      for (int unsigned e = 1; e <= 16; e++) begin
         step();
         slot = (e - 1) / DIV;
         ea12 = 4'b1111 ^ (4'b0001 << slot);
         ea4  = (slot == 1 || slot == 2) ? 4'b1111 : ea12;
         es4  = (slot == 1 || slot == 2) ? 7'b1111111 : 7'b1000000;
         checks++; if (an4 !== ea4) begin errors++; $display("FAIL idle_an4 e=%0d: got %b expected %b", e, an4, ea4); end
         checks++; if (seg4 !== es4) begin errors++; $display("FAIL idle_seg4 e=%0d: got %b expected %b", e, seg4, es4); end
         checks++; if (an12 !== ea12) begin errors++; $display("FAIL idle_an12 e=%0d: got %b expected %b", e, an12, ea12); end
      end
   endtask

   task automatic test_capture();
      logic [6:0] exp12 [4];
      logic [6:0] exp8  [4];
      logic [3:0] ea, ea8;
      int unsigned slot;
      exp12 = '{7'b1000110, 7'b0010010, 7'b0001000, 7'b0001000};
      exp8  = '{7'b1000110, 7'b0010010, 7'b1111111, 7'b0001000};
      do_reset(2);
      value = 12'hA5C; flags = 4'b1010; load = 1'b1;
      step();
      load = 1'b0;
      checks++; if (ack12 !== 1'b1) begin errors++; $display("FAIL cap_ack: got %b expected %b", ack12, 1'b1); end
      checks++; if (rq12 !== 12'hA5C) begin errors++; $display("FAIL cap_result12: got %h expected %h", rq12, 12'hA5C); end
      checks++; if (rq8 !== 8'h5C) begin errors++; $display("FAIL cap_result8: got %h expected %h", rq8, 8'h5C); end
      checks++; if (fq12 !== 4'hA) begin errors++; $display("FAIL cap_flags: got %h expected %h", fq12, 4'hA); end
      checks++; if (seg12 !== 7'b1000000) begin errors++; $display("FAIL cap_seg_latency: got %b expected %b", seg12, 7'b1000000); end
      for (int unsigned e = 2; e <= 16; e++) begin
         step();
         slot = (e - 1) / DIV;
         ea   = 4'b1111 ^ (4'b0001 << slot);
         ea8  = (slot == 2) ? 4'b1111 : ea;
         if (e == 2) begin
            checks++; if (ack12 !== 1'b0) begin errors++; $display("FAIL cap_ack_pulse: got %b expected %b", ack12, 1'b0); end
         end
         checks++; if (an12 !== ea) begin errors++; $display("FAIL cap_an12 e=%0d: got %b expected %b", e, an12, ea); end
         checks++; if (seg12 !== exp12[slot]) begin errors++; $display("FAIL cap_seg12 e=%0d: got %b expected %b", e, seg12, exp12[slot]); end
         checks++; if (an8 !== ea8) begin errors++; $display("FAIL cap_an8 e=%0d: got %b expected %b", e, an8, ea8); end
         checks++; if (seg8 !== exp8[slot]) begin errors++; $display("FAIL cap_seg8 e=%0d: got %b expected %b", e, seg8, exp8[slot]); end
      end
   endtask

   task automatic test_hold();
      hold = 1'b1; load = 1'b1; value = 12'h123; flags = 4'h5;
      repeat (5) begin
         step();
         checks++; if (ack12 !== 1'b0) begin errors++; $display("FAIL hold_ack: got %b expected %b", ack12, 1'b0); end
         checks++; if (rq12 !== 12'hA5C) begin errors++; $display("FAIL hold_result: got %h expected %h", rq12, 12'hA5C); end
         checks++; if (fq12 !== 4'hA) begin errors++; $display("FAIL hold_flags: got %h expected %h", fq12, 4'hA); end
      end
      hold = 1'b0;
      step();
      checks++; if (ack12 !== 1'b1) begin errors++; $display("FAIL unhold_ack: got %b expected %b", ack12, 1'b1); end
      checks++; if (rq12 !== 12'h123) begin errors++; $display("FAIL unhold_result: got %h expected %h", rq12, 12'h123); end
      load = 1'b0;
      step();
      checks++; if (ack12 !== 1'b0) begin errors++; $display("FAIL unhold_ack_end: got %b expected %b", ack12, 1'b0); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ea;
      logic [6:0] es;
      do_reset(2);
      flags = 4'h0;
      for (int unsigned v = 1; v <= 3; v++) begin
         value = 12'(v); load = 1'b1;
         step();
         checks++; if (ack8 !== 1'b1) begin errors++; $display("FAIL b2b_ack v=%0d: got %b expected %b", v, ack8, 1'b1); end
         checks++; if (rq8 !== 8'(v)) begin errors++; $display("FAIL b2b_result v=%0d: got %h expected %h", v, rq8, 8'(v)); end
      end
      load = 1'b0;
      step();
      checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %b expected %b", ack8, 1'b0); end
      checks++; if (rq8 !== 8'h03) begin errors++; $display("FAIL b2b_final: got %h expected %h", rq8, 8'h03); end
      checks++; if (seg8 !== 7'b0110000) begin errors++; $display("FAIL b2b_digit0: got %b expected %b", seg8, 7'b0110000); end
      for (int unsigned e = 5; e <= 12; e++) begin
         step();
         ea = (e <= 8) ? 4'b1101 : 4'b1111;
         es = (e <= 8) ? 7'b1000000 : 7'b1111111;
         checks++; if (an8 !== ea) begin errors++; $display("FAIL b2b_an8 e=%0d: got %b expected %b", e, an8, ea); end
         checks++; if (seg8 !== es) begin errors++; $display("FAIL b2b_seg8 e=%0d: got %b expected %b", e, seg8, es); end
      end
   endtask

   task automatic test_reset_priority();
      logic [3:0] ea;
      do_reset(2);
      value = 12'h7E1; flags = 4'h3; load = 1'b1;
      step();
      load = 1'b0;
      for (int unsigned e = 2; e <= 9; e++) step();
      checks++; if (an12 !== 4'b1011) begin errors++; $display("FAIL prio_pre_an: got %b expected %b", an12, 4'b1011); end
      checks++; if (seg12 !== 7'b1111000) begin errors++; $display("FAIL prio_pre_seg: got %b expected %b", seg12, 7'b1111000); end
      reset = 1'b1; load = 1'b1; value = 12'hFFF;
      step();
      checks++; if (rq12 !== 12'h000) begin errors++; $display("FAIL prio_result: got %h expected %h", rq12, 12'h000); end
      checks++; if (ack12 !== 1'b0) begin errors++; $display("FAIL prio_ack: got %b expected %b", ack12, 1'b0); end
      checks++; if (an12 !== 4'b1111) begin errors++; $display("FAIL prio_an: got %b expected %b", an12, 4'b1111); end
      checks++; if (seg12 !== 7'b1111111) begin errors++; $display("FAIL prio_seg: got %b expected %b", seg12, 7'b1111111); end
      reset = 1'b0; load = 1'b0;
      for (int unsigned e = 1; e <= 5; e++) begin
         step();
         ea = (e <= 4) ? 4'b1110 : 4'b1101;
         checks++; if (an12 !== ea) begin errors++; $display("FAIL prio_restart_an e=%0d: got %b expected %b", e, an12, ea); end
         checks++; if (seg12 !== 7'b1000000) begin errors++; $display("FAIL prio_restart_seg e=%0d: got %b expected %b", e, seg12, 7'b1000000); end
      end
   endtask

   task automatic test_wrap();
      int unsigned en_cnt [4];
      int unsigned slot;
      logic [3:0] ea12, ea4;
      en_cnt = '{0, 0, 0, 0};
      do_reset(2);
      for (int unsigned e = 1; e <= 8 * DIV; e++) begin
         step();
         slot = ((e - 1) / DIV) % 4;
         ea12 = 4'b1111 ^ (4'b0001 << slot);
         ea4  = (slot == 1 || slot == 2) ? 4'b1111 : ea12;
         checks++; if (an12 !== ea12) begin errors++; $display("FAIL wrap_an12 e=%0d: got %b expected %b", e, an12, ea12); end
         checks++; if (an4 !== ea4) begin errors++; $display("FAIL wrap_an4 e=%0d: got %b expected %b", e, an4, ea4); end
         checks++; if ($countones(~an12) > 1) begin errors++; $display("FAIL wrap_onehot e=%0d: got %b expected at most one low bit", e, an12); end
         for (int unsigned i = 0; i < 4; i++) if (an12[i] === 1'b0) en_cnt[i]++;
      end
      for (int unsigned i = 0; i < 4; i++) begin
         checks++; if (en_cnt[i] !== 2 * DIV) begin errors++; $display("FAIL wrap_slot_len digit=%0d: got %0d expected %0d", i, en_cnt[i], 2 * DIV); end
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; hold = 1'b0; value = '0; flags = '0;
      test_reset();
      test_capture();
      test_hold();
      test_back_to_back();
      test_reset_priority();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_result_display.md
# alu_result_display

Output-side counterpart of the ALU operand input register: captures the ALU result and status flags on a load handshake and drives a time-multiplexed 4-digit, active-low 7-segment display. Digits 0–2 show the result in hex and digit 3 shows the flag nibble. It sits between the ALU output and the board display pins and holds the last accepted result until a new load or a reset.

## Interface
- N, default 4: result width, legal 1..12.
- REFRESH_DIV, default 50000: clk cycles per digit time slot, legal ≥2.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- result_in  in  N  ALU result to capture.
- flags_in  in  4  ALU flags {N,Z,C,V} to capture.
- load  in  1  capture request, sampled every rising edge.
- hold  in  1  when high, load is ignored and the captured values stay frozen.
- load_ack  out  1  single-cycle pulse confirming a capture.
- result_q  out  N  captured result.
- flags_q  out  4  captured flags.
- an  out  4  digit enables, active-low; an[i] drives digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Reset (reset sampled high) sets:
  - result_q=0, flags_q=0, load_ack=0.
  - Refresh counter=0, digit select=0.
  - an=4'b1111, seg=7'b1111111.
- Capture: at an edge where load=1, hold=0 and reset=0:
  - result_q←result_in and flags_q←flags_in.
  - load_ack=1 for exactly the following cycle.
- Back-to-back loads: each accepted load overwrites the captured values and produces its own ack, so load_ack stays high continuously.
- If hold=1, load has no effect and no ack is produced.
- If reset=1, reset wins over load.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap, digit select advances 0→1→2→3→0.
- Digit content:
  - Result is zero-extended to 12 bits.
  - Digit 0 = bits[3:0], digit 1 = bits[7:4], digit 2 = bits[11:8], digit 3 = flags_q.
- Blanking:
  - A digit i≤2 with 4·i ≥ N is blanked for its whole slot: an=4'b1111, seg=7'b1111111.
  - The slot still elapses, so the scan period is always 4·REFRESH_DIV.
  - Digit 0 and digit 3 are never blanked.
- Hex encoding (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- For a non-blanked digit i: an has only bit i low, and seg is the encoding of that digit's nibble.
- an and seg are registered. They are computed from the current digit select, result_q and flags_q, and are never both active for two digits at once.

## Timing
- Capture latency: load sampled at edge k; result_q, flags_q and load_ack change at edge k.
- Display latency: an/seg reflect new captured values at edge k+1.
- Reset release:
  - First edge with reset=0: digit select=0 and counter 0→1. an/seg still show reset values until that edge's registered update.
  - From the following cycle: an=4'b1110, seg=1000000.
- Digit slot: each digit is driven for exactly REFRESH_DIV consecutive cycles.
- Digit switch: an/seg switch one cycle after the counter wraps.
- Mid-scan load: the displayed digit updates at edge k+1 without disturbing the counter or the digit select.
- Reset mid-scan: returns to the reset state at the sampling edge; the scan restarts at digit 0.

## Test plan
- Reset/idle: assert reset 3 cycles, release; REFRESH_DIV=4, N=4.
  - During reset: an=1111, seg=1111111, result_q=0.
  - Then: digit0 slot an=1110, seg=1000000 for 4 cycles; digits 1,2 blank for 4 cycles each; digit3 an=0111, seg=1000000.
- Capture/ack: N=12, result_in=12'hA5C, flags_in=4'b1010, pulse load 1 cycle.
  - load_ack high exactly 1 cycle; result_q=A5C.
  - Digits show C (1000110), 5 (0010010), A (0001000), flags A (0001000).
- Hold: hold=1, load=1 with result_in=12'h123 for 5 cycles.
  - No ack; result_q stays A5C.
  - Release hold with load still 1: capture of 123 and ack the next cycle.
- Back-to-back loads: load high 3 cycles with values 1, 2, 3 (N=8).
  - load_ack high 3 consecutive cycles; final result_q=8'h03.
  - Digit1=0 shown, digit2 blanked.
- Reset priority and mid-scan reset: in the digit2 slot, assert reset and load together.
  - result_q=0, no ack.
  - After release, the scan restarts at digit0 with a full 4-cycle slot.
- Wrap: run 2 full scans (32 cycles at REFRESH_DIV=4).
  - Digit order 0,1,2,3,0,…
  - Each digit enabled exactly 4 cycles; never two an bits low at once.
